// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and constants for the two-port memory arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Port indices. Port 0 is the MIPS core, port 1 is the loader/DMA master.
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    // Width of the access latency counter. It must hold MEM_LAT up to 15.
    localparam int LAT_W = 4;

    // Convert a port index into its one-hot acknowledge pattern.
    function automatic logic [1:0] port_onehot(input logic idx);
        return (idx == PORT_AUX) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose : bundles the master request/ack signals and the memory-side bus of mem_arbiter.
// Latency : n/a (wires only).
// Backpressure: masters hold req/we/addr/wdata stable until their ack bit pulses.
// Ports   : req/we/addr*/wdata* and mem_in flow into the arbiter.
//           ack/rdata/busy/address/mem_out/mem_read/mem_write flow out of it.
// Modports: slave  = arbiter side.
//           master = the environment, i.e. the masters plus the memory.
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Master-facing request side.
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // Memory-facing side.
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] mem_out;
    logic [DATA_W-1:0] mem_in;
    logic              mem_read;
    logic              mem_write;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_in,
        output ack, rdata, busy, address, mem_out, mem_read, mem_write
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_in,
        input  ack, rdata, busy, address, mem_out, mem_read, mem_write
    );

endinterface

// File: rtl/arb_pick.sv
// Purpose : combinational winner selection between the two request bits.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the caller samples the result only in IDLE.
// Ports   : req[1:0] and last_grant are inputs; grant_valid and grant_idx are outputs.
// Config  : ARB_ROUND_ROBIN_EN selects alternating priority; otherwise port 0 has fixed priority.
import mem_arb_pkg::*;

module arb_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

`ifdef ARB_ROUND_ROBIN_EN
    // On contention, the port that did not win last time is favoured.
    always_comb begin
        grant_valid = |req;
        grant_idx   = PORT_CORE;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = PORT_AUX;
        end
    end
`else
    // Fixed priority: port 1 is granted only when the core is not asking.
    // With fixed priority the grant history is irrelevant.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = |req;
        grant_idx   = (req[0]) ? PORT_CORE : (req[1] ? PORT_AUX : PORT_CORE);
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : serialises two bus masters onto one single-port memory.
// Latency : strobe is held for MEM_LAT cycles, then a 1-cycle ack; grants are spaced MEM_LAT+2 cycles apart.
// Backpressure: requests are ignored outside IDLE, so masters hold req until their ack pulse.
// Ports   : clk, rst (async, active-low) and bus (mem_arbiter_if.slave).
//           All outputs on bus are registered.
// Config  : define ARB_ROUND_ROBIN_EN for round-robin arbitration.
//           The default is fixed priority with port 0 first.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $error("mem_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              win_q;      // port being served; it steers the ack bit

    logic [1:0]        ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] mem_out_q;
    logic              mem_read_q;
    logic              mem_write_q;

    logic              grant_valid;
    logic              grant_idx;
    logic              last_grant;
    logic              sel_we;

`ifdef ARB_ROUND_ROBIN_EN
    // Reset value PORT_AUX makes the core win the first contention.
    logic last_grant_q;
    assign last_grant = last_grant_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PORT_AUX;
        end else if (state == IDLE && grant_valid) begin
            last_grant_q <= grant_idx;
        end
    end
`else
    assign last_grant = PORT_AUX;
`endif

    arb_pick u_pick (
        .req         (bus.req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_we = bus.we[grant_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            win_q       <= PORT_CORE;
            ack_q       <= 2'b00;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            address_q   <= '0;
            mem_out_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 2'b00;
                    if (grant_valid) begin
                        address_q   <= (grant_idx == PORT_AUX) ? bus.addr1  : bus.addr0;
                        mem_out_q   <= (grant_idx == PORT_AUX) ? bus.wdata1 : bus.wdata0;
                        mem_read_q  <= ~sel_we;
                        mem_write_q <= sel_we;
                        lat_cnt     <= LAT_W'(MEM_LAT);
                        win_q       <= grant_idx;
                        busy_q      <= 1'b1;
                        state       <= BUSY;
                    end
                end

                BUSY: begin
                    // The last strobe cycle is the one where the counter reads 1.
                    // The strobes drop in the same edge that raises ack.
                    // As a result, ack and a strobe are never high together.
                    if (lat_cnt == LAT_W'(1)) begin
                        if (mem_read_q) begin
                            rdata_q <= bus.mem_in;
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        ack_q       <= port_onehot(win_q);
                        state       <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                RESP: begin
                    ack_q  <= 2'b00;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    ack_q       <= 2'b00;
                    busy_q      <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.address   = address_q;
    assign bus.mem_out   = mem_out_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed bench for mem_arbiter at MEM_LAT=1 (dut1) and MEM_LAT=3 (dut3).
// Latency : checks strobe/ack cycle placement against MEM_LAT.
// Backpressure: masters hold requests until ack, as a real master would.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    // ---------------- memory models (16 words, word-addressed by address[5:2]) ----------------
    function automatic logic [31:0] init_word(input logic [3:0] idx);
        case (idx)
            4'd3:    return 32'hCAFEF00D;
            4'd4:    return 32'hDEADBEEF;
            default: return {8{idx}};
        endcase
    endfunction

    logic [31:0] m1 [16];
    logic [31:0] m3 [16];
    logic [15:0] v1 = '0;
    logic [15:0] v3 = '0;

    always @(posedge clk) begin
        if (bus1.mem_write) begin
            m1[bus1.address[5:2]] <= bus1.mem_out;
            v1[bus1.address[5:2]] <= 1'b1;
        end
        if (bus3.mem_write) begin
            m3[bus3.address[5:2]] <= bus3.mem_out;
            v3[bus3.address[5:2]] <= 1'b1;
        end
    end

    assign bus1.mem_in = v1[bus1.address[5:2]] ? m1[bus1.address[5:2]] : init_word(bus1.address[5:2]);
    assign bus3.mem_in = v3[bus3.address[5:2]] ? m3[bus3.address[5:2]] : init_word(bus3.address[5:2]);

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    logic [1:0]  s_ack;
    logic [31:0] s_rdata;
    logic        s_busy;
    logic [31:0] s_addr;
    logic [31:0] s_mout;
    logic        s_rd;
    logic        s_wr;

    task automatic sample(input bit sel);
        if (sel) begin
            s_ack = bus3.ack;  s_rdata = bus3.rdata;  s_busy = bus3.busy;
            s_addr = bus3.address; s_mout = bus3.mem_out;
            s_rd = bus3.mem_read; s_wr = bus3.mem_write;
        end else begin
            s_ack = bus1.ack;  s_rdata = bus1.rdata;  s_busy = bus1.busy;
            s_addr = bus1.address; s_mout = bus1.mem_out;
            s_rd = bus1.mem_read; s_wr = bus1.mem_write;
        end
    endtask

    task automatic drive(input bit sel, input logic [1:0] rq, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        if (sel) begin
            bus3.req = rq; bus3.we = w; bus3.addr0 = a0; bus3.addr1 = a1;
            bus3.wdata0 = d0; bus3.wdata1 = d1;
        end else begin
            bus1.req = rq; bus1.we = w; bus1.addr0 = a0; bus1.addr1 = a1;
            bus1.wdata0 = d0; bus1.wdata1 = d1;
        end
    endtask

    function automatic bit all_zero();
        return (s_ack == 2'b00) && (s_rdata == 32'h0) && !s_busy &&
               (s_addr == 32'h0) && (s_mout == 32'h0) && !s_rd && !s_wr;
    endfunction

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        logic [31:0] exp_addr;
        logic [1:0]  exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    // One complete transaction: drive, watch strobe/ack timing, then release req.
    task automatic run_txn(input bit sel, input int lat, input vec_t v, input string nm);
        int          stb_first;
        int          stb_cnt;
        int          ack_cyc;
        logic [1:0]  ack_seen;
        logic [31:0] rd_seen;
        logic [31:0] addr_seen;
        logic [31:0] mout_seen;
        logic        rd_t;
        logic        wr_t;
        bit          overlap;
        bit          busy_ok;
        logic        w_we;
        logic [31:0] w_dat;

        stb_first = -1; stb_cnt = 0; ack_cyc = -1; overlap = 0; busy_ok = 1;
        ack_seen = '0; rd_seen = '0; addr_seen = '0; mout_seen = '0; rd_t = 0; wr_t = 0;
        @(negedge clk);
        drive(sel, v.req, v.we, v.addr0, v.addr1, v.wdata0, v.wdata1);
        for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
            @(negedge clk);
            sample(sel);
            if (!s_busy) busy_ok = 0;
            if (s_rd || s_wr) begin
                if (stb_first < 0) begin
                    stb_first = k; addr_seen = s_addr; mout_seen = s_mout;
                    rd_t = s_rd; wr_t = s_wr;
                end
                stb_cnt++;
            end
            if (s_ack != 2'b00) begin
                ack_cyc = k; ack_seen = s_ack; rd_seen = s_rdata;
                if (s_rd || s_wr) overlap = 1;
            end
        end
        drive(sel, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);

        w_we  = v.exp_ack[1] ? v.we[1] : v.we[0];
        w_dat = v.exp_ack[1] ? v.wdata1 : v.wdata0;
        check({nm, " ack_timeout"}, 64'(ack_cyc >= 0), 64'd1);
        check({nm, " strobe_first_cycle"}, 64'(stb_first), 64'd1);
        check({nm, " strobe_cycles"}, 64'(stb_cnt), 64'(lat));
        check({nm, " ack_cycle"}, 64'(ack_cyc), 64'(lat + 1));
        check({nm, " ack"}, 64'(ack_seen), 64'(v.exp_ack));
        check({nm, " rdata"}, 64'(rd_seen), 64'(v.exp_rdata));
        check({nm, " address"}, 64'(addr_seen), 64'(v.exp_addr));
        check({nm, " strobe_kind"}, 64'({rd_t, wr_t}), 64'({~w_we, w_we}));
        if (w_we) check({nm, " mem_out"}, 64'(mout_seen), 64'(w_dat));
        check({nm, " ack_strobe_overlap"}, 64'(overlap), 64'd0);
        check({nm, " busy"}, 64'(busy_ok), 64'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    vec_t vecs [7];

    initial begin
        bit          bad1;
        bit          bad3;
        int          n_gr;
        int          gr_cyc [4];
        logic [1:0]  gr_ack [4];
        logic [31:0] gr_dat [4];
        logic [1:0]  exp_ord [4];
        bit          bad;

        // MEM_LAT=1 directed vectors, executed in order on dut1. Hand-computed.
        vecs[0] = '{2'b01, 2'b00, 32'h10, 32'h0,  32'h0,        32'h0,        32'h10, 2'b01, 32'hDEADBEEF};
        vecs[1] = '{2'b10, 2'b10, 32'h0,  32'h20, 32'h0,        32'h12345678, 32'h20, 2'b10, 32'hDEADBEEF};
        vecs[2] = '{2'b01, 2'b00, 32'h20, 32'h0,  32'h0,        32'h0,        32'h20, 2'b01, 32'h12345678};
        vecs[3] = '{2'b10, 2'b00, 32'h0,  32'h10, 32'h0,        32'h0,        32'h10, 2'b10, 32'hDEADBEEF};
        vecs[4] = '{2'b01, 2'b01, 32'h04, 32'h0,  32'hA5A5A5A5, 32'h0,        32'h04, 2'b01, 32'hDEADBEEF};
        vecs[5] = '{2'b10, 2'b00, 32'h0,  32'h04, 32'h0,        32'h0,        32'h04, 2'b10, 32'hA5A5A5A5};
        vecs[6] = '{2'b11, 2'b01, 32'h08, 32'h10, 32'h0BADF00D, 32'h0,        32'h08, 2'b01, 32'hA5A5A5A5};

`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_ord = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        // ---- reset only ----
        rst1 = 1'b0; rst3 = 1'b0;
        drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #10;
        sample(0); check("reset_during_dut1", 64'(all_zero()), 64'd1);
        sample(1); check("reset_during_dut3", 64'(all_zero()), 64'd1);
        #10;
        rst1 = 1'b1; rst3 = 1'b1;
        bad1 = 0; bad3 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sample(0); if (!all_zero()) bad1 = 1;
            sample(1); if (!all_zero()) bad3 = 1;
        end
        check("reset_idle_dut1", 64'(bad1), 64'd0);
        check("reset_idle_dut3", 64'(bad3), 64'd0);

        // ---- table of single transactions, MEM_LAT=1 ----
        for (int i = 0; i < 7; i++) begin
            run_txn(0, 1, vecs[i], $sformatf("vec%0d", i));
        end

        // ---- contention: req=11 held for 4 grants from a fresh reset ----
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        drive(0, 2'b11, 2'b00, 32'h10, 32'h04, 32'h0, 32'h0);
        n_gr = 0;
        for (int k = 1; k <= 40 && n_gr < 4; k++) begin
            @(negedge clk);
            sample(0);
            if (s_ack != 2'b00) begin
                gr_cyc[n_gr] = k; gr_ack[n_gr] = s_ack; gr_dat[n_gr] = s_rdata;
                n_gr++;
            end
        end
        drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        check("contend_grant_count", 64'(n_gr), 64'd4);
        for (int i = 0; i < n_gr; i++) begin
            check($sformatf("contend_order%0d", i), 64'(gr_ack[i]), 64'(exp_ord[i]));
            check($sformatf("contend_rdata%0d", i), 64'(gr_dat[i]),
                  64'((exp_ord[i] == 2'b10) ? 32'hA5A5A5A5 : 32'hDEADBEEF));
            if (i > 0) check($sformatf("contend_spacing%0d", i), 64'(gr_cyc[i] - gr_cyc[i-1]), 64'd3);
        end
        @(negedge clk);
        @(negedge clk);

        // ---- MEM_LAT=3 read latency ----
        run_txn(1, 3, '{2'b01, 2'b00, 32'h0C, 32'h0, 32'h0, 32'h0, 32'h0C, 2'b01, 32'hCAFEF00D}, "lat3_read");

        // ---- reset in the middle of a MEM_LAT=3 access ----
        @(negedge clk);
        drive(1, 2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
        @(negedge clk);               // cycle 1: first strobe cycle
        @(negedge clk);               // cycle 2: second strobe cycle
        sample(1);
        check("midrst_strobe_before", 64'(s_rd), 64'd1);
        rst3 = 1'b0;
        #1;
        sample(1);
        check("midrst_strobes_dropped", 64'({s_rd, s_wr}), 64'd0);
        check("midrst_busy_dropped", 64'(s_busy), 64'd0);
        drive(1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sample(1);
            if (s_ack != 2'b00 || s_rd || s_wr || s_busy) bad = 1;
        end
        check("midrst_no_ack_idle", 64'(bad), 64'd0);

        // Re-request after reset must be served normally.
        run_txn(1, 3, '{2'b10, 2'b00, 32'h0, 32'h10, 32'h0, 32'h0, 32'h10, 2'b10, 32'hDEADBEEF}, "lat3_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
